// File: rtl/issue_inst_queue_if.sv
// Port bundle for issue_inst_queue: the fetch push side, the two issue output slots,
// the pop handshake and the occupancy count. master = fetch/issue side, slave = queue.
interface issue_inst_queue_if #(
  parameter int CNT_W = 4
);
  // Fetch side: up to two instructions per cycle, slot 0 older
  logic             f_valid0_i;
  logic             f_valid1_i;
  logic [31:0]      f_inst0_i;
  logic [31:0]      f_inst1_i;
  logic [31:0]      f_pc0_i;
  logic [31:0]      f_pc1_i;
  logic             f_pred0_i;
  logic             f_pred1_i;
  logic [31:0]      f_pred_tgt0_i;
  logic [31:0]      f_pred_tgt1_i;
  logic             fetch_ready_o;

  // Issue side: two oldest entries, slot 0 older
  logic             q_valid0_o;
  logic             q_valid1_o;
  logic [31:0]      q_inst0_o;
  logic [31:0]      q_inst1_o;
  logic [31:0]      q_pc0_o;
  logic [31:0]      q_pc1_o;
  logic             q_pred0_o;
  logic             q_pred1_o;
  logic [31:0]      q_pred_tgt0_o;
  logic [31:0]      q_pred_tgt1_o;
  logic             pop0_i;
  logic             pop1_i;

  logic             flush_i;
  logic [CNT_W-1:0] count_o;

  modport master (
    output f_valid0_i, f_valid1_i, f_inst0_i, f_inst1_i, f_pc0_i, f_pc1_i,
           f_pred0_i, f_pred1_i, f_pred_tgt0_i, f_pred_tgt1_i,
           pop0_i, pop1_i, flush_i,
    input  fetch_ready_o,
           q_valid0_o, q_valid1_o, q_inst0_o, q_inst1_o, q_pc0_o, q_pc1_o,
           q_pred0_o, q_pred1_o, q_pred_tgt0_o, q_pred_tgt1_o, count_o
  );

  modport slave (
    input  f_valid0_i, f_valid1_i, f_inst0_i, f_inst1_i, f_pc0_i, f_pc1_i,
           f_pred0_i, f_pred1_i, f_pred_tgt0_i, f_pred_tgt1_i,
           pop0_i, pop1_i, flush_i,
    output fetch_ready_o,
           q_valid0_o, q_valid1_o, q_inst0_o, q_inst1_o, q_pc0_o, q_pc1_o,
           q_pred0_o, q_pred1_o, q_pred_tgt0_o, q_pred_tgt1_o, count_o
  );
endinterface

// File: rtl/issue_inst_queue.sv
// Dual-ported in-order instruction queue between fetch and the dual-issue stage.
// Optional INSTQ_BYPASS_EN: fetch entries feed empty output slots in the same cycle.
module issue_inst_queue #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clock_i,
  input  logic              reset_i,
  issue_inst_queue_if.slave q_if
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
    logic [31:0] pred_tgt;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  entry_t           f_ent0;
  entry_t           f_ent1;
  entry_t           st_ent0;
  entry_t           st_ent1;
  entry_t           sel0;
  entry_t           sel1;
  entry_t           q_ent0;
  entry_t           q_ent1;
  entry_t           wr_ent0;

  logic             fetch_ready;
  logic             f_take0;
  logic             f_take1;
  logic             q_valid0;
  logic             q_valid1;
  logic [1:0]       pushes;
  logic [1:0]       pops;
  logic [1:0]       bypass_pops;
  logic [1:0]       writes;
  logic [1:0]       st_pops;

  assign f_ent0 = {q_if.f_inst0_i, q_if.f_pc0_i, q_if.f_pred0_i, q_if.f_pred_tgt0_i};
  assign f_ent1 = {q_if.f_inst1_i, q_if.f_pc1_i, q_if.f_pred1_i, q_if.f_pred_tgt1_i};

  // Ready uses only the registered count; a same-cycle pop gives no credit.
  assign fetch_ready = (count <= CNT_W'(DEPTH - 2));

  assign f_take0 = q_if.f_valid0_i & fetch_ready & ~q_if.flush_i;
  assign f_take1 = f_take0 & q_if.f_valid1_i;
  assign pushes  = {1'b0, f_take0} + {1'b0, f_take1};

  assign st_ent0 = mem[rd_ptr];
  assign st_ent1 = mem[rd_ptr + PTR_W'(1)];

  // Output slot sourcing
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    q_valid0 = 1'b0;
    q_valid1 = 1'b0;
    sel0     = st_ent0;
    sel1     = st_ent1;
`ifdef INSTQ_BYPASS_EN
    if (count == '0) begin
      q_valid0 = f_take0;
      q_valid1 = f_take1;
      sel0     = f_ent0;
      sel1     = f_ent1;
    end else if (count == CNT_W'(1)) begin
      q_valid0 = 1'b1;
      q_valid1 = f_take0;
      sel1     = f_ent0;
    end else begin
      q_valid0 = 1'b1;
      q_valid1 = 1'b1;
    end
`else
    q_valid0 = (count != '0);
    q_valid1 = (count >= CNT_W'(2));
`endif
  end

  assign q_ent0 = q_valid0 ? sel0 : '0;
  assign q_ent1 = q_valid1 ? sel1 : '0;

  assign pops = {1'b0, q_if.pop0_i & q_valid0}
              + {1'b0, q_if.pop0_i & q_if.pop1_i & q_valid1};

  // Pops that consumed fetch entries directly are never written to storage.
`ifdef INSTQ_BYPASS_EN
  always_comb begin
    bypass_pops = 2'd0;
    if (count == '0)
      bypass_pops = pops;
    else if (count == CNT_W'(1) && pops == 2'd2)
      bypass_pops = 2'd1;
  end
`else
  assign bypass_pops = 2'd0;
`endif

  assign writes  = pushes - bypass_pops;
  assign st_pops = pops - bypass_pops;
  assign wr_ent0 = (bypass_pops == 2'd0) ? f_ent0 : f_ent1;

  // Pointers and occupancy; flush and reset both return to the empty state.
  always_ff @(posedge clock_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset_i || q_if.flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(st_pops);
      wr_ptr <= wr_ptr + PTR_W'(writes);
      count  <= count + CNT_W'(pushes) - CNT_W'(pops);
    end
  end

  // NOTE: entry storage is not reset; validity comes only from the count and pointers.
  always_ff @(posedge clock_i) begin
    if (writes != 2'd0)
      mem[wr_ptr] <= wr_ent0;
    if (writes == 2'd2)
      mem[wr_ptr + PTR_W'(1)] <= f_ent1;
  end

  assign q_if.fetch_ready_o = fetch_ready;
  assign q_if.count_o       = count;

  assign q_if.q_valid0_o    = q_valid0;
  assign q_if.q_inst0_o     = q_ent0.inst;
  assign q_if.q_pc0_o       = q_ent0.pc;
  assign q_if.q_pred0_o     = q_ent0.pred;
  assign q_if.q_pred_tgt0_o = q_ent0.pred_tgt;

  assign q_if.q_valid1_o    = q_valid1;
  assign q_if.q_inst1_o     = q_ent1.inst;
  assign q_if.q_pc1_o       = q_ent1.pc;
  assign q_if.q_pred1_o     = q_ent1.pred;
  assign q_if.q_pred_tgt1_o = q_ent1.pred_tgt;

endmodule

// File: doc/issue_inst_queue.md
Name: issue_inst_queue

Overview:
- Dual-ported instruction queue between fetch/predict and the dual-issue stage.
- Accepts 0–2 fetched instructions per cycle, in program order.
- Presents the two oldest entries to issue as slot 0 (older) and slot 1 (younger).
- Retires 0, 1 or 2 entries per cycle. A pop of 1 handles a slot-1 special stall: the unissued younger instruction becomes next cycle's slot 0.
- Flush on redirect (mispredict or trap).

Parameters:
- DEPTH, 8: number of entries. Power of two, ≥4.
- CNT_W, $clog2(DEPTH)+1: width of the occupancy counter.

Ports:
- clock_i  in  1  clock; all state updates on the rising edge.
- reset_i  in  1  synchronous reset, active-high.
- flush_i  in  1  discard all entries and all pushes this cycle.
- f_valid0_i  in  1  fetch slot 0 valid.
- f_valid1_i  in  1  fetch slot 1 valid. Honoured only with f_valid0_i.
- f_inst0_i, f_inst1_i  in  32  instruction words.
- f_pc0_i, f_pc1_i  in  32  PCs.
- f_pred0_i, f_pred1_i  in  1  predicted-taken.
- f_pred_tgt0_i, f_pred_tgt1_i  in  32  predicted targets.
- fetch_ready_o  out  1  queue can accept two entries this cycle.
- q_valid0_o, q_valid1_o  out  1  output slot valid.
- q_inst0_o, q_inst1_o  out  32.
- q_pc0_o, q_pc1_o  out  32.
- q_pred0_o, q_pred1_o  out  1.
- q_pred_tgt0_o, q_pred_tgt1_o  out  32.
- pop0_i  in  1  issue consumed slot 0.
- pop1_i  in  1  issue consumed slot 1. Honoured only with pop0_i.
- count_o  out  CNT_W  current occupancy.

Behaviour:
- Storage:
  - Each entry holds {inst, pc, pred, pred_tgt} (97 bits).
  - rd_ptr and wr_ptr are log2(DEPTH)-bit pointers that wrap modulo DEPTH.
  - The occupancy counter is a separate register.
- Reset, and the cycle after reset:
  - rd_ptr = wr_ptr = 0, count_o = 0.
  - q_valid0_o = q_valid1_o = 0.
  - fetch_ready_o = 1.
  - All q_* data outputs = 0.
- Ready: fetch_ready_o = (count ≤ DEPTH-2), computed from the registered count only. No same-cycle pop credit.
- Push count:
  - pushes = f_valid0_i + (f_valid0_i & f_valid1_i).
  - Forced to 0 when fetch_ready_o = 0 or flush_i = 1. Fetch holds its data when not ready.
  - Slot 0 is written at wr_ptr, slot 1 at wr_ptr+1 (wrapping). wr_ptr advances by pushes.
- Output slots:
  - q_valid0_o = (count ≥ 1); q_valid1_o = (count ≥ 2).
  - Data comes combinationally from entry rd_ptr (slot 0) and rd_ptr+1 (slot 1).
  - An invalid slot drives all-zero data.
- Pop count:
  - pops = (pop0_i & q_valid0_o) + (pop0_i & pop1_i & q_valid1_o).
  - Ignored pops are silently dropped: pop1_i without pop0_i, or a pop on an invalid slot.
  - rd_ptr advances by pops.
- Counter update: count_next = count + pushes − pops, all in the same cycle. Push and pop never conflict, because at most DEPTH-2+2 entries exist.
- Ordering: the slot-0 output is always the oldest unissued instruction.
  - pop of 1: old slot 1 becomes new slot 0 next cycle, with its PC, prediction and target preserved.
- Wrap-around: pointer arithmetic is modulo DEPTH. A slot-1 read or write at index DEPTH-1+1 maps to entry 0.
- Flush:
  - Next cycle: count = 0, rd_ptr = wr_ptr = 0, q_valid* = 0.
  - Flush overrides pushes and pops in the same cycle.
- Reset overrides flush. Reset mid-stream discards all entries with no residue.
- Latency: a pushed entry is visible at the outputs the cycle after the push (no bypass build).

Optional Feature:
- Macro: INSTQ_BYPASS_EN.
- Enabled, no flush: output slot k (k = 0,1) is sourced from the queue if k < count, otherwise from fetch slot (k − count) when that fetch slot is valid and fetch_ready_o = 1.
  - Empty queue gives zero-cycle fetch-to-issue latency.
  - Fetch entries popped in the same cycle are not written.
  - wr_ptr advances by pushes − bypass_pops; count_next is unchanged in form.
- Disabled: outputs come from storage only; one-cycle minimum latency.

Test Plan:
- Reset, then push two entries {pc=0x00, 0x04} with pops held low -> next cycle: q_valid0/1 = 1, q_pc0 = 0x00, q_pc1 = 0x04, count_o = 2.
- With entries {0x00, 0x04, 0x08} queued, pop0 = 1, pop1 = 0 (slot-1 stall) -> next cycle: q_pc0 = 0x04, q_pc1 = 0x08, count_o = 2.
- Fill to count = 7 with DEPTH = 8 -> fetch_ready_o = 0; pushes ignored; count stays 7. Pop two -> count 5, fetch_ready_o = 1.
- Push/pop continuously for 20 cycles, two in and two out per cycle across the pointer wrap -> PCs emerge strictly ascending by 4 with no gaps; count stable.
- flush_i together with push2 and pop2 at count = 4 -> next cycle: count_o = 0, q_valid0 = 0, fetch_ready_o = 1.
- INSTQ_BYPASS_EN, empty queue, push {0x40, 0x44} with pop0 = pop1 = 1 -> same cycle: q_pc0 = 0x40, q_pc1 = 0x44; next cycle count_o = 0.
